watch_sequencer: RTL
====================

# watch_sequencer

Control and counting core for the 4-digit MM:SS clock display. Debounces the two pushbuttons, runs the timer/stopwatch state machine, and maintains four BCD digit counters from a 1 Hz tick derived from CLOCK_50. Its digit outputs feed the dynamic-lighting display driver; LED and ssLED report mode and state on board LEDs.

## Interface
- TICK_DIV, 50_000_000: CLOCK_50 cycles per count tick (1 s).
- DEBOUNCE_CYC, 1_000_000: cycles a synchronized key level must be stable before it is accepted (20 ms).
- PRESET, 16'h0300: timer load value, packed BCD {min tens, min ones, sec tens, sec ones}; sec tens ≤ 5.
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- KEY  in  2  pushbuttons, active-low, asynchronous; KEY[0] start/stop, KEY[1] mode/clear.
- LED  out  1  mode: 0 = timer (count down), 1 = stopwatch (count up).
- ssLED  out  2  state: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- dig1_cntr  out  4  seconds ones (BCD).
- dig2_cntr  out  4  seconds tens (0–5).
- dig3_cntr  out  4  minutes ones.
- dig4_cntr  out  4  minutes tens.
- done  out  1  one-cycle pulse when timer reaches 00:00.

## Operation
- Key path, per key: 2-flop synchronizer → stable counter → debounced level; a press event is one cycle on debounced 1→0.
- States: IDLE, RUN, PAUSE, DONE.
- KEY[0] press: IDLE→RUN; RUN→PAUSE; PAUSE→RUN; DONE→IDLE with digits reloaded.
- KEY[1] press: IDLE toggles mode, then loads digits (timer: PRESET, stopwatch: 00:00); PAUSE loads the current mode's value and goes to IDLE; DONE→IDLE with reload; ignored in RUN.
- Both press events in the same cycle: KEY[0] acts, KEY[1] discarded.
- Prescaler counts 0..TICK_DIV-1 only in RUN; it holds its value in PAUSE; it clears on IDLE→RUN and on any reload.
- Tick, stopwatch: seconds 0–59 with carry into minutes 00–99; 99:59 wraps to 00:00 and counting continues.
- Tick, timer: BCD decrement with borrow (xx:00 → (xx-1):59).
- Timer reaching 00:00 enters DONE and pulses done in the same cycle the digits become 00:00.
- Timer started at 00:00: RUN for exactly one cycle, then DONE with a done pulse; no tick is consumed.
- DONE holds 00:00. The prescaler is idle.
- Reset values: state IDLE, LED 0, ssLED 00, digits = PRESET, done 0, prescaler 0, debounced levels 1 (released), synchronizers 1.

## Timing
- Key latency: KEY edge → 2 sync cycles → DEBOUNCE_CYC stable cycles → press event → state and outputs update on the next edge.
- Bounce shorter than DEBOUNCE_CYC produces no event. Release also needs DEBOUNCE_CYC of stability before the next press is recognized.
- First tick arrives TICK_DIV cycles after entering RUN from IDLE. After PAUSE→RUN, the remaining fraction carries over.
- Digits update one cycle after the prescaler hits TICK_DIV-1. All outputs are registered.
- RESET mid-count: outputs go to reset values asynchronously. Counting resumes only after a fresh KEY[0] press.

## Structure
- Package watch_pkg: state enum with ssLED encodings, mode constants MODE_TIMER/MODE_SW, 4-bit BCD digit type, BCD-increment/decrement helper functions.
- Sub-module key_debounce (synchronizer + stable counter + falling-edge event), instantiated once per key, parameterized by DEBOUNCE_CYC.
- Top-level FSM, prescaler and BCD cascade live in watch_sequencer.

## Test plan
Bench settings: TICK_DIV=4, DEBOUNCE_CYC=3, PRESET=16'h0102.
- Reset, then release → digits 01:02, LED=0, ssLED=00, done=0.
- KEY[0] press → RUN; after 3 ticks digits go 01:01 → 01:00 → 00:59; after 59 more ticks, 00:00 with a one-cycle done and ssLED=11.
- KEY[1] press in IDLE → LED=1, digits 00:00; KEY[0] press → RUN; preload 99:59 via ticks (or force), one tick → 00:00 and still RUN.
- RUN, KEY[0] press mid-prescale (count 2) → PAUSE with digits frozen; KEY[0] press → first tick after 2 cycles, not 4.
- KEY[0] glitch low for 2 cycles → no state change; KEY[0] and KEY[1] pressed in the same cycle from IDLE → RUN, mode unchanged.
- RESET asserted during RUN at 00:45 → immediate 01:02, IDLE, LED=0.

Source files
------------

// File: rtl/watch_sequencer_pkg.sv
// Shared types and BCD helpers for the MM:SS watch sequencer.
// State encodings double as the ssLED pattern shown on the board.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic MODE_TIMER = 1'b0;
  localparam logic MODE_SW    = 1'b1;

  typedef logic [3:0] bcd_t;

  // Digit wraps to 0 once it reaches max_d; caller decides on carry.
  function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t max_d);
    return (d >= max_d) ? bcd_t'(0) : bcd_t'(d + 4'd1);
  endfunction

  // Digit borrows back to max_d from 0.
  function automatic bcd_t bcd_dec(input bcd_t d, input bcd_t max_d);
    return (d == 4'd0) ? max_d : bcd_t'(d - 4'd1);
  endfunction

endpackage

// File: rtl/watch_sequencer_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and
// a one-cycle press event on the debounced falling edge.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_ff;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= 2'b11;
      level   <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], key_n};
      press   <= 1'b0;
      // Level flips only after DEBOUNCE_CYC consecutive differing samples.
      if (sync_ff[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync_ff[1];
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/watch_sequencer.sv
// Timer/stopwatch control core: key conditioning, mode/state FSM,
// 1 Hz prescaler and the four-digit BCD MM:SS counter.
module watch_sequencer
  import watch_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter logic [15:0] PRESET       = 16'h0300
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [1:0] KEY,
  output logic       LED,
  output logic [1:0] ssLED,
  output logic [3:0] dig1_cntr,
  output logic [3:0] dig2_cntr,
  output logic [3:0] dig3_cntr,
  output logic [3:0] dig4_cntr,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [1:0]    key_press;
  state_t        state, state_nxt;
  logic          mode, mode_nxt;
  logic          done_q, done_nxt;
  logic          load, presc_clr, step;
  logic [PW-1:0] presc;
  logic [15:0]   digits, stepped, reload;
  logic          tick;

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
      .clk   (CLOCK_50),
      .rst   (RESET),
      .key_n (KEY[i]),
      .press (key_press[i])
    );
  end

  assign tick   = (state == ST_RUN) && (presc == PRESC_MAX);
  assign reload = (mode_nxt == MODE_TIMER) ? PRESET : '0;

  // One-second step of the MM:SS cascade in the current direction.
  always_comb begin
    stepped = digits;
    if (mode == MODE_SW) begin
      stepped[3:0] = bcd_inc(digits[3:0], 4'd9);
      if (digits[3:0] == 4'd9) begin
        stepped[7:4] = bcd_inc(digits[7:4], 4'd5);
        if (digits[7:4] == 4'd5) begin
          stepped[11:8] = bcd_inc(digits[11:8], 4'd9);
          if (digits[11:8] == 4'd9) stepped[15:12] = bcd_inc(digits[15:12], 4'd9);
        end
      end
    end else begin
      stepped[3:0] = bcd_dec(digits[3:0], 4'd9);
      if (digits[3:0] == 4'd0) begin
        stepped[7:4] = bcd_dec(digits[7:4], 4'd5);
        if (digits[7:4] == 4'd0) begin
          stepped[11:8] = bcd_dec(digits[11:8], 4'd9);
          if (digits[11:8] == 4'd0) stepped[15:12] = bcd_dec(digits[15:12], 4'd9);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state  <= ST_IDLE;
      mode   <= MODE_TIMER;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode   <= mode_nxt;
      done_q <= done_nxt;
    end
  end

  // KEY[0] is tested first everywhere, so a same-cycle KEY[1] is dropped.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    load      = 1'b0;
    presc_clr = 1'b0;
    step      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_press[0]) begin
          state_nxt = ST_RUN;
          presc_clr = 1'b1;
        end else if (key_press[1]) begin
          mode_nxt = ~mode;
          load     = 1'b1;
        end
      end
      ST_RUN: begin
        if (key_press[0]) begin
          state_nxt = ST_PAUSE;
        end else if (mode == MODE_TIMER && digits == 16'h0000) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else if (tick) begin
          step = 1'b1;
          if (mode == MODE_TIMER && stepped == 16'h0000) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (key_press[0]) begin
          state_nxt = ST_RUN;
        end else if (key_press[1]) begin
          state_nxt = ST_IDLE;
          load      = 1'b1;
        end
      end
      ST_DONE: begin
        if (key_press[0] || key_press[1]) begin
          state_nxt = ST_IDLE;
          load      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Prescaler advances only while staying in RUN, so PAUSE keeps the fraction.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      digits <= PRESET;
      presc  <= '0;
    end else begin
      if (load)      digits <= reload;
      else if (step) digits <= stepped;
      if (load || presc_clr) presc <= '0;
      else if (state == ST_RUN && state_nxt == ST_RUN)
        presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
    end
  end

  always_comb begin
    LED       = mode;
    ssLED     = state;
    dig1_cntr = digits[3:0];
    dig2_cntr = digits[7:4];
    dig3_cntr = digits[11:8];
    dig4_cntr = digits[15:12];
    done      = done_q;
  end

endmodule
